// File: rtl/quad_uart_pkg.sv
// Shared types and constants for the quad UART Wishbone master.
package quad_uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBus,
      StResp
   } state_e;

   localparam int unsigned UartIdxW = 2;
   localparam int unsigned RegW     = 3;

   // 16550-style register offsets within one UART instance
   localparam logic [RegW-1:0] RegRbThr  = 3'd0;
   localparam logic [RegW-1:0] RegIer    = 3'd1;
   localparam logic [RegW-1:0] RegIirFcr = 3'd2;
   localparam logic [RegW-1:0] RegLcr    = 3'd3;
   localparam logic [RegW-1:0] RegMcr    = 3'd4;
   localparam logic [RegW-1:0] RegLsr    = 3'd5;
   localparam logic [RegW-1:0] RegMsr    = 3'd6;
   localparam logic [RegW-1:0] RegScr    = 3'd7;

   typedef struct packed {
      logic                we;
      logic [UartIdxW-1:0] uart;
      logic [RegW-1:0]     reg_off;
      logic [7:0]          wdata;
   } cmd_t;

   // One-hot byte select for the lane a register offset maps onto
   function automatic logic [3:0] lane_sel(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

   // Extract the addressed byte lane from a 32-bit bus word
   function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
      return data[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/quad_uart_cmd_fifo.sv
// Synchronous show-ahead FIFO of host commands; Depth must be a power of two.
module quad_uart_cmd_fifo
   import quad_uart_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  cmd_t wdata_i,
   input  logic pop_i,
   output cmd_t rdata_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   cmd_t            mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointer and occupancy update; a push while full is taken only alongside a pop
   always_comb begin
      do_push  = push_i & (~full_o | pop_i);
      do_pop   = pop_i & ~empty_o;
      wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy guards reads
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/quad_uart_wb_master.sv
// Wishbone classic master fronting the quad UART: one host command -> one bus cycle,
// bounded by an ack timeout. Define QUAD_UART_WB_CMD_FIFO_EN to buffer commands in a FIFO.
module quad_uart_wb_master
   import quad_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [UartIdxW-1:0]   cmd_uart_i,
   input  logic [RegW-1:0]       cmd_reg_i,
   input  logic [7:0]            cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [7:0]            rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [31:0]           wb_adr_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic                  wb_we_o,
   output logic [3:0]            wb_sel_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i
);

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("quad_uart_wb_master: DATA_WIDTH must be 32");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("quad_uart_wb_master: TIMEOUT_CYCLES must be 1..65535");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("quad_uart_wb_master: FIFO_DEPTH must be a power of two >= 2");
   end

   localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   cmd_t            host_cmd;
   cmd_t            start_cmd;
   logic            start;

   assign host_cmd = {cmd_we_i, cmd_uart_i, cmd_reg_i, cmd_wdata_i};

`ifdef QUAD_UART_WB_CMD_FIFO_EN
   logic fifo_full, fifo_empty;

   // Ready is gated by reset so the host sees 0 while the block is held in reset
   assign cmd_ready_o = wb_rst_n_i & ~fifo_full;
   assign start       = (state_q == StIdle) & ~fifo_empty;

   quad_uart_cmd_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_n_i),
      .push_i  (cmd_valid_i & cmd_ready_o),
      .wdata_i (host_cmd),
      .pop_i   (start),
      .rdata_o (start_cmd),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
`else
   assign cmd_ready_o = wb_rst_n_i & (state_q == StIdle);
   assign start       = cmd_valid_i & cmd_ready_o;
   assign start_cmd   = host_cmd;
`endif

   // Next-state logic: launch, hold stb until ack or terminal count, then hold the response
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StBus;
               cnt_d   = '0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = start_cmd.we;
               sel_d   = lane_sel(start_cmd.reg_off[1:0]);
               adr_d   = {27'd0, start_cmd.uart, start_cmd.reg_off};
               dat_d   = {4{start_cmd.wdata}};
            end
         end
         StBus: begin
            // Ack wins over a simultaneous terminal count
            if (wb_ack_i || cnt_q == CntLast) begin
               state_d     = StResp;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               sel_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ~wb_ack_i;
               rsp_rdata_d = (wb_ack_i && !we_q) ? lane_byte(wb_dat_i, adr_q[1:0]) : 8'h00;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 8'h00;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered bus/response outputs; reset drops cyc/stb asynchronously
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_we_o     = we_q;
   assign wb_sel_o    = sel_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_quad_uart_wb_master.sv
// Randomized self-checking bench for quad_uart_wb_master with a behavioural slave.
module tb_quad_uart_wb_master;
   import quad_uart_pkg::*;

   localparam int unsigned To    = 8;
   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        wb_rst_n_i;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [1:0]  cmd_uart_i;
   logic [2:0]  cmd_reg_i;
   logic [7:0]  cmd_wdata_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [7:0]  rsp_rdata_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
   logic [3:0]  wb_sel_o;

   int          n_checks = 0;
   int          n_fail = 0;
   int          ack_delay = -1;
   logic [31:0] slave_rdata = '0;
   int          stb_cnt = 0;

   always #5 clk = ~clk;

   quad_uart_wb_master #(
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (To),
      .FIFO_DEPTH     (Depth)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (wb_rst_n_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_uart_i  (cmd_uart_i),
      .cmd_reg_i   (cmd_reg_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_we_o     (wb_we_o),
      .wb_sel_o    (wb_sel_o),
      .wb_stb_o    (wb_stb_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_ack_i    (wb_ack_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave: acks during the (ack_delay+1)-th cycle of stb; ack_delay < 0 never acks
   initial begin
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      forever begin
         @(negedge clk);
         if (wb_cyc_o && wb_stb_o) begin
            if (stb_cnt == ack_delay) begin
               wb_ack_i = 1'b1;
               wb_dat_i = slave_rdata;
            end else begin
               wb_ack_i = 1'b0;
               wb_dat_i = $urandom;
            end
            stb_cnt++;
         end else begin
            wb_ack_i = 1'b0;
            stb_cnt  = 0;
         end
      end
   end

   // One command end to end; expectations come from the timeout rule and byte-lane arithmetic
   task automatic run_cmd(input bit we, input bit [1:0] uart, input bit [2:0] rg,
                          input bit [7:0] wd, input int delay, input bit [31:0] sdata,
                          input int hold);
      bit       exp_err;
      bit [7:0] exp_rd;
      int       exp_stb;
      int       stb_seen;
      int       n;
      bit       fields_done;
      exp_err = (delay < 0) || (delay >= int'(To));
      exp_rd  = (we || exp_err) ? 8'h00 : 8'((sdata >> (8 * (rg % 4))) & 32'hFF);
      exp_stb = exp_err ? int'(To) : delay + 1;
      ack_delay   = delay;
      slave_rdata = sdata;
      check_eq("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_uart_i  = uart;
      cmd_reg_i   = rg;
      cmd_wdata_i = wd;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      stb_seen    = 0;
      fields_done = 1'b0;
      n           = 0;
      while (!rsp_valid_o && n < 200) begin
         if (wb_stb_o) begin
            stb_seen++;
            if (!fields_done) begin
               fields_done = 1'b1;
               check_eq("adr", wb_adr_o, {27'd0, uart, rg});
               check_eq("sel", {28'd0, wb_sel_o}, 32'd1 << (rg % 4));
               check_eq("dat", wb_dat_o, 32'(wd) * 32'h0101_0101);
               check_eq("we", {31'd0, wb_we_o}, {31'd0, we});
               check_eq("cyc", {31'd0, wb_cyc_o}, 32'd1);
`ifndef QUAD_UART_WB_CMD_FIFO_EN
               check_eq("cmd_ready_busy", {31'd0, cmd_ready_o}, 32'd0);
`endif
            end
         end
         @(negedge clk);
         n++;
      end
      check_eq("rsp_wait_bound", {31'd0, n < 200}, 32'd1);
      check_eq("stb_cycles", stb_seen, exp_stb);
      check_eq("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
      check_eq("rsp_rdata", {24'd0, rsp_rdata_o}, {24'd0, exp_rd});
      check_eq("stb_low_in_resp", {31'd0, wb_stb_o}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
         check_eq("hold_rdata", {24'd0, rsp_rdata_o}, {24'd0, exp_rd});
         check_eq("hold_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
         check_eq("hold_no_stb", {31'd0, wb_stb_o}, 32'd0);
`ifndef QUAD_UART_WB_CMD_FIFO_EN
         check_eq("hold_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
`endif
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check_eq("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
   endtask

   // Back-to-back commands against a slow slave; responses must come back in push order
   task automatic run_burst();
      cmd_t     cmds [5];
      bit [7:0] exp_rd [5];
      int       first_stall;
      int       got;
      ack_delay   = 4;
      slave_rdata = 32'hA1B2_C3D4;
      for (int i = 0; i < 5; i++) begin
         cmds[i].we      = (i == 4);
         cmds[i].uart    = 2'($urandom_range(0, 3));
         cmds[i].reg_off = 3'(i % 4) + (($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0);
         cmds[i].wdata   = 8'($urandom);
         exp_rd[i] = cmds[i].we ? 8'h00 : 8'(slave_rdata >> (8 * (i % 4)));
      end
      first_stall = -1;
      got = 0;
      fork
         begin
            int pushed = 0;
            int m = 0;
            while (pushed < 5 && m < 400) begin
               cmd_valid_i = 1'b1;
               {cmd_we_i, cmd_uart_i, cmd_reg_i, cmd_wdata_i} = cmds[pushed];
               if (cmd_ready_o) pushed++;
               else if (first_stall < 0) first_stall = pushed;
               @(negedge clk);
               m++;
            end
            cmd_valid_i = 1'b0;
            check_eq("burst_push_bound", {31'd0, pushed == 5}, 32'd1);
         end
         begin
            int m = 0;
            while (got < 5 && m < 400) begin
               @(negedge clk);
               m++;
               if (rsp_valid_o && !rsp_ready_i) begin
                  check_eq("burst_rdata", {24'd0, rsp_rdata_o}, {24'd0, exp_rd[got]});
                  check_eq("burst_err", {31'd0, rsp_err_o}, 32'd0);
                  got++;
                  rsp_ready_i = 1'b1;
               end else begin
                  rsp_ready_i = 1'b0;
               end
            end
            @(negedge clk);
            rsp_ready_i = 1'b0;
         end
      join
      check_eq("burst_rsp_count", got, 32'd5);
`ifdef QUAD_UART_WB_CMD_FIFO_EN
      check_eq("burst_fifo_stall",
               {31'd0, first_stall >= int'(Depth) && first_stall <= int'(Depth) + 1}, 32'd1);
`else
      check_eq("burst_stall_after_one", first_stall, 32'd1);
`endif
   endtask

   initial begin
      int dtab [8] = '{0, 1, 2, 3, 5, 7, 8, -1};
      bit seen;
      wb_rst_n_i  = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_uart_i  = '0;
      cmd_reg_i   = '0;
      cmd_wdata_i = '0;
      rsp_ready_i = 1'b0;
      #1;
      check_eq("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      check_eq("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check_eq("rst_adr", wb_adr_o, 32'd0);
      check_eq("rst_dat", wb_dat_o, 32'd0);
      check_eq("rst_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'd0);
      check_eq("rst_rsp", {22'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, 32'd0);
      repeat (3) @(negedge clk);
      wb_rst_n_i = 1'b1;
      @(negedge clk);

      // Directed: LCR write, LSR read, timeouts and the ack-at-terminal-count boundary
      run_cmd(1'b1, 2'd2, RegLcr, 8'h83, 3, 32'h0, 0);
      run_cmd(1'b0, 2'd1, RegLsr, 8'h00, 1, 32'h0000_6000, 0);
      run_cmd(1'b0, 2'd0, RegRbThr, 8'h00, -1, 32'h1234_5678, 0);
      run_cmd(1'b0, 2'd3, RegMsr, 8'h00, int'(To) - 1, 32'hDEAD_BEEF, 0);
      run_cmd(1'b0, 2'd3, RegIirFcr, 8'h00, int'(To), 32'hCAFE_F00D, 0);
      run_cmd(1'b0, 2'd1, RegScr, 8'h00, 0, 32'h89AB_CDEF, 5);

      for (int k = 0; k < 20; k++) begin
         run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 8'($urandom), dtab[$urandom_range(0, 7)], $urandom, $urandom_range(0, 2));
      end

      run_burst();

      // Reset mid-cycle: cyc/stb must drop without a clock edge and no response may follow
      ack_delay   = -1;
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b0;
      cmd_uart_i  = 2'd2;
      cmd_reg_i   = RegIer;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      @(negedge clk);
      check_eq("pre_reset_stb", {31'd0, wb_stb_o}, 32'd1);
      #2 wb_rst_n_i = 1'b0;
      #1;
      check_eq("async_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check_eq("async_rst_adr", wb_adr_o, 32'd0);
      check_eq("async_rst_ready", {31'd0, cmd_ready_o}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      wb_rst_n_i = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (rsp_valid_o || wb_stb_o) seen = 1'b1;
      end
      check_eq("no_rsp_after_reset", {31'd0, seen}, 32'd0);
      run_cmd(1'b0, 2'd0, RegMcr, 8'h00, 2, 32'h5566_7788, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_uart_wb_master.md
Name: quad_uart_wb_master

Overview:
- Wishbone bus master that sits directly upstream of the quad UART block.
- Converts single host register commands (valid/ready) into one Wishbone classic cycle each: UART index plus register offset in, read data or error status out.
- Bounds every bus cycle with an ack timeout so a hung slave cannot stall the host.
- Drives byte lanes and address so each of the four UART instances is selected by address bits [4:3].

Parameters:
DATA_WIDTH, 32, Wishbone data width; only 32 supported, checked at elaboration.
TIMEOUT_CYCLES, 255, max cycles stb held without ack before abort; range 1..65535.
FIFO_DEPTH, 4, command FIFO entries (used only with QUAD_UART_WB_CMD_FIFO_EN); power of two, >=2.

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  host command valid
cmd_ready_o  out  1  host command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_uart_i  in  2  target UART index 0..3
cmd_reg_i  in  3  UART register offset 0..7
cmd_wdata_i  in  8  write byte
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  host accepts response
rsp_rdata_o  out  8  read byte (0 for writes and errors)
rsp_err_o  out  1  1=ack timeout
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte select
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  acknowledge

Behaviour:
- Reset is asynchronous and active-low. While wb_rst_n_i=0: all outputs are 0, except cmd_ready_o=0 and wb_adr_o/wb_dat_o=0. The FSM is in IDLE and the timeout counter is 0.
- FSM states:
  - IDLE: cmd_ready_o=1. A handshake captures the command and moves to BUS on the next edge.
  - BUS: wb_cyc_o=wb_stb_o=1. wb_adr_o={27'b0, uart, reg}. wb_we_o=we. wb_sel_o=4'b0001<<reg[1:0]. wb_dat_o={4{wdata}}.
  - BUS exits: if wb_ack_i=1, go to RESP with rdata=we?0:wb_dat_i[8*reg[1:0]+:8] and err=0. If the counter reaches TIMEOUT_CYCLES-1 without ack, go to RESP with rdata=0 and err=1.
  - RESP: cyc/stb/we/sel deasserted. rsp_valid_o=1, and rdata/err are held stable until rsp_ready_i=1. Then return to IDLE.
- All Wishbone outputs are registered.
- Latency: handshake at edge 0, stb high from edge 1, ack sampled at edge N, rsp_valid_o high from edge N. Minimum is 2 cycles from command to response.
- Exactly one outstanding cycle at a time. stb never deasserts before ack or timeout.
- An ack in the same cycle as the timeout terminal count counts as success (err=0).
- wb_ack_i is ignored outside BUS.
- The counter resets to 0 on entry to BUS.
- Reset mid-cycle: cyc/stb drop asynchronously, and any pending response is discarded.

Optional Feature:
QUAD_UART_WB_CMD_FIFO_EN
- Defined: commands pass through a FIFO_DEPTH-entry FIFO.
  - cmd_ready_o=!fifo_full, independent of FSM state.
  - The FSM leaves IDLE when the FIFO is non-empty and pops on entry to BUS.
  - Command order is preserved.
  - Push and pop in the same cycle when full is allowed; occupancy is unchanged.
- Undefined: no FIFO; cmd_ready_o=(state==IDLE), as described above.

Decomposition:
- quad_uart_pkg holds:
  - state enum {IDLE, BUS, RESP}
  - register offset constants: RB_THR=0, IER=1, IIR_FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, SCR=7
  - UART_IDX_W=2 and REG_W=3
  - a packed command struct {we, uart, reg, wdata}
- One sub-module, quad_uart_cmd_fifo (synchronous FIFO of the command struct), instantiated only under QUAD_UART_WB_CMD_FIFO_EN.

Test Plan:
- Write uart=2, reg=3 (LCR), wdata=8'h83, ack 3 cycles later:
  - wb_adr_o=32'h13, wb_sel_o=4'b1000, wb_dat_o=32'h83838383, wb_we_o=1.
  - Response has err=0 and rdata=0.
- Read uart=1, reg=5 (LSR), slave returns wb_dat_i=32'h0000_6000 with ack after 1 cycle -> wb_adr_o=32'h0D, wb_sel_o=4'b0010, rsp_rdata_o=8'h60.
- Read with no ack, TIMEOUT_CYCLES=8:
  - stb stays high exactly 8 cycles, then drops.
  - Response has err=1 and rdata=0.
  - The next command proceeds normally.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles:
  - rsp_valid_o and data stay stable.
  - cmd_ready_o=0 (FIFO off).
  - No new stb.
- Assert wb_rst_n_i low while wb_stb_o=1 -> cyc/stb go to 0 immediately with no clock edge, and no response follows after reset release.
- FIFO on: push 5 commands back-to-back with a slow slave -> cmd_ready_o deasserts after 4, and responses come out in push order.
